// File: rtl/nts_pkg.sv
// Shared types and constants for the NTS receive-path parser sequencer.
// No logic; state encoding, parser opcode and stats selectors only.
// Backpressure: not applicable.
package nts_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_SAMPLE,
        ST_RESULT,
        ST_RELEASE
    } state_t;

    localparam logic [3:0] OPCODE_NTP_OFFSET = 4'h0;

    localparam logic [1:0] STATS_SEL_FRAMES   = 2'd0;
    localparam logic [1:0] STATS_SEL_ACCEPTED = 2'd1;
    localparam logic [1:0] STATS_SEL_DROPPED  = 2'd2;

endpackage

// File: rtl/nts_stats_counter.sv
// Saturating 32-bit event counter, cleared by reset only.
// Latency: count visible the cycle after i_inc.
// Backpressure: none; increments at the all-ones value are dropped.
module nts_stats_counter (
    input  logic        i_clk,
    input  logic        i_areset_n,
    input  logic        i_inc,
    output logic [31:0] o_count
);

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_count <= '0;
        end else if (i_inc && (o_count != 32'hFFFF_FFFF)) begin
            o_count <= o_count + 32'd1;
        end
    end

endmodule

// File: rtl/nts_parser_ctrl.sv
// Sequences one buffered RX frame through the header parser and reports accept/drop + NTP offset.
// Latency: first read 2 cycles after i_rx_available, verdict N+4 cycles after it (N words).
// Backpressure: verdict held until i_result_ack; optional counters under NTS_PARSER_CTRL_STATS_EN.
module nts_parser_ctrl
    import nts_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_areset_n,
    input  logic                  i_rx_available,
    input  logic [ADDR_WIDTH:0]   i_rx_words,
    input  logic [7:0]            i_rx_last_valid,
    output logic                  o_rx_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rx_rd_addr,
    input  logic [63:0]           i_rx_rd_data,
    output logic                  o_rx_release,
    output logic                  o_parser_clear,
    output logic                  o_parser_process,
    output logic [63:0]           o_parser_data,
    output logic [7:0]            o_parser_last_valid,
    output logic [3:0]            o_parser_opcode,
    input  logic                  i_parser_ipv4,
    input  logic                  i_parser_ipv4_bad,
    input  logic [31:0]           i_parser_rdata,
    input  logic                  i_abort,
    output logic                  o_result_valid,
    output logic                  o_result_accept,
    output logic [ADDR_WIDTH+3:0] o_ntp_offset,
    input  logic                  i_result_ack,
`ifdef NTS_PARSER_CTRL_STATS_EN
    input  logic [1:0]            i_stats_sel,
    output logic [31:0]           o_stats,
`endif
    output logic                  o_busy
);

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH+1)'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     words_q;
    logic [7:0]              mask_q;
    logic [ADDR_WIDTH:0]     cnt_q;
    logic                    proc_q;
    logic                    last_q;
    logic                    accept_q;
    logic [ADDR_WIDTH+3:0]   offset_q;

    logic [ADDR_WIDTH:0]     words_in;
    logic                    take_frame;
    logic                    abort_hit;
    logic                    rd_fire;
    logic                    last_rd;
    logic                    accept_now;
    logic                    sample_ok;
    logic                    unused_rdata;

    assign unused_rdata = ^i_parser_rdata[31:ADDR_WIDTH+4];

    // Lengths beyond the buffer size are clamped so the read address never wraps.
    assign words_in   = (i_rx_words > MAX_WORDS) ? MAX_WORDS : i_rx_words;
    assign take_frame = (state_q == ST_IDLE) && i_rx_available;
    assign abort_hit  = i_abort && ((state_q == ST_CLEAR) || (state_q == ST_STREAM) ||
                                    (state_q == ST_DRAIN) || (state_q == ST_SAMPLE));
    assign rd_fire    = (state_q == ST_STREAM) && !i_abort;
    assign last_rd    = (cnt_q == (words_q - ONE_WORD));
    assign accept_now = i_parser_ipv4 && !i_parser_ipv4_bad;
    assign sample_ok  = (state_q == ST_SAMPLE) && !abort_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (i_rx_available) state_d = (words_in == '0) ? ST_RELEASE : ST_CLEAR;
            ST_CLEAR:   state_d = ST_STREAM;
            ST_STREAM:  if (last_rd) state_d = ST_DRAIN;
            ST_DRAIN:   state_d = ST_SAMPLE;
            ST_SAMPLE:  state_d = ST_RESULT;
            ST_RESULT:  if (i_result_ack) state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort_hit) state_d = ST_RELEASE;
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q  <= ST_IDLE;
            words_q  <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            proc_q   <= 1'b0;
            last_q   <= 1'b0;
            accept_q <= 1'b0;
            offset_q <= '0;
        end else begin
            state_q <= state_d;
            proc_q  <= rd_fire;
            last_q  <= rd_fire && last_rd;
            if (take_frame) begin
                words_q <= words_in;
                mask_q  <= i_rx_last_valid;
            end
            if (state_q == ST_CLEAR) begin
                cnt_q <= '0;
            end else if (rd_fire) begin
                cnt_q <= cnt_q + ONE_WORD;
            end
            if (sample_ok) begin
                offset_q <= i_parser_rdata[ADDR_WIDTH+3:0];
                accept_q <= accept_now;
            end
        end
    end

    // A word already in flight when an abort lands is not handed to the parser.
    assign o_rx_rd_en          = rd_fire;
    assign o_rx_rd_addr        = rd_fire ? cnt_q[ADDR_WIDTH-1:0] : '0;
    assign o_parser_clear      = (state_q == ST_CLEAR) || abort_hit;
    assign o_parser_process    = proc_q && !abort_hit;
    assign o_parser_data       = o_parser_process ? i_rx_rd_data : '0;
    assign o_parser_last_valid = o_parser_process ? (last_q ? mask_q : 8'hFF) : 8'h00;
    assign o_parser_opcode     = OPCODE_NTP_OFFSET;
    assign o_result_valid      = (state_q == ST_RESULT);
    assign o_result_accept     = (state_q == ST_RESULT) && accept_q;
    assign o_ntp_offset        = offset_q;
    assign o_rx_release        = (state_q == ST_RELEASE);
    assign o_busy              = (state_q != ST_IDLE);

`ifdef NTS_PARSER_CTRL_STATS_EN
    logic [31:0] cnt_frames, cnt_accepted, cnt_dropped;
    logic        inc_dropped;

    assign inc_dropped = (sample_ok && !accept_now) || abort_hit ||
                         (take_frame && (words_in == '0));

    nts_stats_counter u_cnt_frames (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_inc      (take_frame),
        .o_count    (cnt_frames)
    );

    nts_stats_counter u_cnt_accepted (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_inc      (sample_ok && accept_now),
        .o_count    (cnt_accepted)
    );

    nts_stats_counter u_cnt_dropped (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_inc      (inc_dropped),
        .o_count    (cnt_dropped)
    );

    always_comb begin
        o_stats = '0;
        case (i_stats_sel)
            STATS_SEL_FRAMES:   o_stats = cnt_frames;
            STATS_SEL_ACCEPTED: o_stats = cnt_accepted;
            STATS_SEL_DROPPED:  o_stats = cnt_dropped;
            default:            o_stats = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_nts_parser_ctrl.sv
// Directed bench for nts_parser_ctrl: RX buffer model, parser flags driven per frame.
// Inputs change 1ns after the rising edge; outputs are observed on the falling edge.
`timescale 1ns/1ps
module tb_nts_parser_ctrl;

    localparam int AW = 10;

    logic          i_clk = 1'b0;
    logic          i_areset_n;
    logic          i_rx_available;
    logic [AW:0]   i_rx_words;
    logic [7:0]    i_rx_last_valid;
    logic          o_rx_rd_en;
    logic [AW-1:0] o_rx_rd_addr;
    logic [63:0]   i_rx_rd_data = '0;
    logic          o_rx_release;
    logic          o_parser_clear;
    logic          o_parser_process;
    logic [63:0]   o_parser_data;
    logic [7:0]    o_parser_last_valid;
    logic [3:0]    o_parser_opcode;
    logic          i_parser_ipv4;
    logic          i_parser_ipv4_bad;
    logic [31:0]   i_parser_rdata;
    logic          i_abort;
    logic          o_result_valid;
    logic          o_result_accept;
    logic [AW+3:0] o_ntp_offset;
    logic          i_result_ack;
    logic          o_busy;
`ifdef NTS_PARSER_CTRL_STATS_EN
    logic [1:0]    i_stats_sel = 2'd0;
    logic [31:0]   o_stats;
`endif

    always #5 i_clk = ~i_clk;

    nts_parser_ctrl #(.ADDR_WIDTH(AW)) dut (
        .i_clk               (i_clk),
        .i_areset_n          (i_areset_n),
        .i_rx_available      (i_rx_available),
        .i_rx_words          (i_rx_words),
        .i_rx_last_valid     (i_rx_last_valid),
        .o_rx_rd_en          (o_rx_rd_en),
        .o_rx_rd_addr        (o_rx_rd_addr),
        .i_rx_rd_data        (i_rx_rd_data),
        .o_rx_release        (o_rx_release),
        .o_parser_clear      (o_parser_clear),
        .o_parser_process    (o_parser_process),
        .o_parser_data       (o_parser_data),
        .o_parser_last_valid (o_parser_last_valid),
        .o_parser_opcode     (o_parser_opcode),
        .i_parser_ipv4       (i_parser_ipv4),
        .i_parser_ipv4_bad   (i_parser_ipv4_bad),
        .i_parser_rdata      (i_parser_rdata),
        .i_abort             (i_abort),
        .o_result_valid      (o_result_valid),
        .o_result_accept     (o_result_accept),
        .o_ntp_offset        (o_ntp_offset),
        .i_result_ack        (i_result_ack),
`ifdef NTS_PARSER_CTRL_STATS_EN
        .i_stats_sel         (i_stats_sel),
        .o_stats             (o_stats),
`endif
        .o_busy              (o_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [63:0] rx_word(input logic [AW-1:0] a);
        return {16'hA5C3, 6'd0, a, 32'h1357_0000 | {22'd0, a}};
    endfunction

    // RX buffer: synchronous read, data one cycle after the strobe.
    always @(posedge i_clk) if (o_rx_rd_en) i_rx_rd_data <= rx_word(o_rx_rd_addr);

    logic [AW:0] exp_words = '0;
    logic [7:0]  exp_mask  = '0;
    int rd_cnt = 0, proc_cnt = 0, clr_cnt = 0, vld_cnt = 0, data_bad = 0;
    int idx = 0, last_proc_cyc = 0;

    always @(negedge i_clk) begin
        if (o_rx_rd_en) rd_cnt++;
        if (o_result_valid) vld_cnt++;
        if (o_parser_clear) begin
            clr_cnt++;
            idx = 0;
        end
        if (o_parser_process) begin
            if (o_parser_data !== rx_word(idx[AW-1:0])) data_bad++;
            if (o_parser_last_valid !== ((idx == int'(exp_words) - 1) ? exp_mask : 8'hFF)) data_bad++;
            if (idx > 0 && cyc != last_proc_cyc + 1) data_bad++;
            last_proc_cyc = cyc;
            idx++;
            proc_cnt++;
        end
    end

    int fstart, b_rd, b_proc, b_clr, b_vld, b_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic look();
        @(negedge i_clk);
    endtask

    task automatic start_frame(input logic [AW:0] words, input logic [7:0] mask);
        tick();
        i_rx_available  = 1'b1;
        i_rx_words      = words;
        i_rx_last_valid = mask;
        exp_words       = words;
        exp_mask        = mask;
        fstart = cyc;
        b_rd = rd_cnt; b_proc = proc_cnt; b_clr = clr_cnt; b_vld = vld_cnt; b_bad = data_bad;
        look();
    endtask

    task automatic wait_valid(input string tag, input int lat);
        while (!o_result_valid && (cyc - fstart) < 100) look();
        chk(tag, 64'(cyc - fstart), 64'(lat));
    endtask

    task automatic ack_release(input string tag);
        tick();
        i_result_ack = 1'b1;
        look();
        chk({tag, "_vld_at_ack"}, 64'(o_result_valid), 64'd1);
        chk({tag, "_no_rel_yet"}, 64'(o_rx_release), 64'd0);
        tick();
        i_result_ack   = 1'b0;
        i_rx_available = 1'b0;
        look();
        chk({tag, "_release"}, 64'(o_rx_release), 64'd1);
        chk({tag, "_vld_drop"}, 64'(o_result_valid), 64'd0);
        tick();
        look();
        chk({tag, "_rel_pulse"}, 64'(o_rx_release), 64'd0);
        chk({tag, "_idle"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        i_areset_n = 1'b0; i_rx_available = 1'b0; i_rx_words = '0; i_rx_last_valid = '0;
        i_parser_ipv4 = 1'b0; i_parser_ipv4_bad = 1'b0; i_parser_rdata = '0;
        i_abort = 1'b0; i_result_ack = 1'b0;
        tick(); tick(); look();
        chk("rst_rd_en",   64'(o_rx_rd_en), 64'd0);
        chk("rst_clear",   64'(o_parser_clear), 64'd0);
        chk("rst_valid",   64'(o_result_valid), 64'd0);
        chk("rst_offset",  64'(o_ntp_offset), 64'd0);
        chk("rst_busy",    64'(o_busy), 64'd0);
        chk("rst_opcode",  64'(o_parser_opcode), 64'd0);
        tick();
        i_areset_n = 1'b1;

        // 12-word IPv4 frame, IHL=5, NTP offset 0x052
        i_parser_ipv4 = 1'b1; i_parser_ipv4_bad = 1'b0; i_parser_rdata = 32'hABCD_0052;
        start_frame(11'd12, 8'h0F);
        chk("f1_c0_busy", 64'(o_busy), 64'd0);
        look();
        chk("f1_c1_clear", 64'(o_parser_clear), 64'd1);
        chk("f1_c1_rd_en", 64'(o_rx_rd_en), 64'd0);
        look();
        chk("f1_c2_rd_en", 64'(o_rx_rd_en), 64'd1);
        chk("f1_c2_addr",  64'(o_rx_rd_addr), 64'd0);
        look();
        chk("f1_c3_addr",  64'(o_rx_rd_addr), 64'd1);
        chk("f1_c3_proc",  64'(o_parser_process), 64'd1);
        wait_valid("f1_latency", 16);
        chk("f1_accept",   64'(o_result_accept), 64'd1);
        chk("f1_offset",   64'(o_ntp_offset), 64'h052);
        chk("f1_reads",    64'(rd_cnt - b_rd), 64'd12);
        chk("f1_procs",    64'(proc_cnt - b_proc), 64'd12);
        chk("f1_clears",   64'(clr_cnt - b_clr), 64'd1);
        chk("f1_data",     64'(data_bad - b_bad), 64'd0);
        ack_release("f1");

        // IHL=6: dropped; verdict held stable through a 20-cycle ack stall
        i_parser_ipv4 = 1'b1; i_parser_ipv4_bad = 1'b1; i_parser_rdata = 32'h0000_1234;
        start_frame(11'd5, 8'h01);
        wait_valid("f2_latency", 9);
        i_parser_ipv4_bad = 1'b0; i_parser_rdata = 32'h0000_0777;
        for (int i = 0; i < 20; i++) begin
            look();
            chk("f2_hold_vld", 64'(o_result_valid), 64'd1);
            chk("f2_hold_off", 64'(o_ntp_offset), 64'h1234);
            chk("f2_hold_acc", 64'(o_result_accept), 64'd0);
        end
        chk("f2_data", 64'(data_bad - b_bad), 64'd0);
        ack_release("f2");

        // ethertype 0x86DD: not IPv4
        i_parser_ipv4 = 1'b0; i_parser_ipv4_bad = 1'b0; i_parser_rdata = 32'h0;
        start_frame(11'd3, 8'h3F);
        wait_valid("f3_latency", 7);
        chk("f3_accept", 64'(o_result_accept), 64'd0);
        chk("f3_offset", 64'(o_ntp_offset), 64'd0);
        chk("f3_procs",  64'(proc_cnt - b_proc), 64'd3);
        ack_release("f3");

        // zero-length frame: straight to release
        start_frame(11'd0, 8'h00);
        look();
        chk("z_release", 64'(o_rx_release), 64'd1);
        chk("z_clear",   64'(o_parser_clear), 64'd0);
        tick();
        i_rx_available = 1'b0;
        look();
        chk("z_rel_pulse", 64'(o_rx_release), 64'd0);
        chk("z_busy",      64'(o_busy), 64'd0);
        chk("z_reads",     64'(rd_cnt - b_rd), 64'd0);
        chk("z_clears",    64'(clr_cnt - b_clr), 64'd0);
        chk("z_verdict",   64'(vld_cnt - b_vld), 64'd0);

        // abort on the third STREAM cycle
        i_parser_ipv4 = 1'b1; i_parser_rdata = 32'h0000_0052;
        start_frame(11'd8, 8'h07);
        look(); look(); look();
        tick();
        i_abort = 1'b1;
        look();
        chk("ab_rd_en", 64'(o_rx_rd_en), 64'd0);
        chk("ab_clear", 64'(o_parser_clear), 64'd1);
        chk("ab_proc",  64'(o_parser_process), 64'd0);
        tick();
        i_abort = 1'b0;
        i_rx_available = 1'b0;
        look();
        chk("ab_release",  64'(o_rx_release), 64'd1);
        chk("ab_clear_off", 64'(o_parser_clear), 64'd0);
        tick();
        look();
        chk("ab_idle",    64'(o_busy), 64'd0);
        chk("ab_reads",   64'(rd_cnt - b_rd), 64'd2);
        chk("ab_clears",  64'(clr_cnt - b_clr), 64'd2);
        chk("ab_verdict", 64'(vld_cnt - b_vld), 64'd0);

        // frame after abort
        start_frame(11'd4, 8'h80);
        wait_valid("f5_latency", 8);
        chk("f5_accept", 64'(o_result_accept), 64'd1);
        chk("f5_offset", 64'(o_ntp_offset), 64'h052);
        chk("f5_procs",  64'(proc_cnt - b_proc), 64'd4);
        chk("f5_data",   64'(data_bad - b_bad), 64'd0);
        ack_release("f5");

        // asynchronous reset mid-STREAM
        start_frame(11'd6, 8'hFF);
        look(); look(); look();
        tick();
        i_areset_n = 1'b0;
        #1;
        chk("ar_rd_en",  64'(o_rx_rd_en), 64'd0);
        chk("ar_addr",   64'(o_rx_rd_addr), 64'd0);
        chk("ar_proc",   64'(o_parser_process), 64'd0);
        chk("ar_data",   o_parser_data, 64'd0);
        chk("ar_lv",     64'(o_parser_last_valid), 64'd0);
        chk("ar_busy",   64'(o_busy), 64'd0);
        chk("ar_offset", 64'(o_ntp_offset), 64'd0);
        chk("ar_rel",    64'(o_rx_release), 64'd0);
        i_rx_available = 1'b0;
        tick();
        i_areset_n = 1'b1;
        tick();
        look();
        chk("ar_after_idle", 64'(o_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
